alu_control_seq: RTL

- Registered, multi-cycle successor to the combinational ALU-function decoder.
- Accepts a decode request (main-control alu_op plus R-type funct) over a valid/ready handshake and drives a registered ALU function code.
- Holds the code stable for the full latency of multi-cycle ops (mult/div) and reports busy/done/illegal status.
- Sits between the main control unit and the ALU in the multi-cycle datapath.

---
 rtl/alu_control_seq.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_control_seq.sv
// ---------------------------------------------------------------------------
// alu_control_seq
//
// Registered, multi-cycle ALU-function decoder. Takes a decode request
// (main-control alu_op plus R-type funct) over a valid/ready handshake and
// drives a registered ALU function code. The code is held stable for the
// whole latency of mult/div. Busy/done/jr/illegal status is reported
// alongside it.
//
// Optional feature (compile-time macro ALU_CTRL_ILLEGAL_TRAP_EN):
//   defined   - an illegal request sets a sticky trap: illegal stays 1 and
//               in_ready stays 0 until rst_n is asserted.
//   undefined - illegal is a one-cycle pulse and the block accepts new
//               requests again on the following cycle.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   request present
//   in_ready   out  block can accept a request this cycle
//   alu_op     in   00=add, 01=sub, 10=decode funct, 11=illegal
//   funct      in   R-type funct field (used only when alu_op=10)
//   alu_fun    out  registered ALU function code
//   fun_valid  out  alu_fun is valid for the ALU this cycle
//   busy       out  multi-cycle op in progress
//   done       out  pulse on the final cycle of any legal op
//   jr         out  pulse alongside a decoded jr
//   illegal    out  pulse (or sticky level with the trap) on a bad request
// ---------------------------------------------------------------------------
module alu_control_seq #(
    parameter int FUNCT_W     = 6,
    parameter int FUN_W       = 4,
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 8,
    parameter int CNT_W       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         alu_op,
    input  logic [FUNCT_W-1:0] funct,
    output logic [FUN_W-1:0]   alu_fun,
    output logic               fun_valid,
    output logic               busy,
    output logic               done,
    output logic               jr,
    output logic               illegal
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [FUN_W-1:0]   alu_fun_reg, alu_fun_next;
    logic               multi_reg, multi_next;
    logic               div_reg, div_next;
    logic               jr_reg, jr_next;
    logic               illegal_reg, illegal_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;

    logic [FUN_W-1:0]   dec_fun;
    logic               dec_multi;
    logic               dec_div;
    logic               dec_jr;
    logic               dec_illegal;

    logic               op_done;
    logic               ready_int;
    logic               accept;
    logic               trap_active;

    // -----------------------------------------------------------------------
    // Request decoder (purely combinational on the incoming request)
    // -----------------------------------------------------------------------
    always_comb begin
        dec_fun     = '0;
        dec_multi   = 1'b0;
        dec_div     = 1'b0;
        dec_jr      = 1'b0;
        dec_illegal = 1'b0;
        case (alu_op)
            2'b00: dec_fun = FUN_W'(4'b0001);
            2'b01: dec_fun = FUN_W'(4'b0010);
            2'b10: begin
                case (funct)
                    FUNCT_W'(6'b100000): dec_fun = FUN_W'(4'b0001);
                    FUNCT_W'(6'b100010): dec_fun = FUN_W'(4'b0010);
                    FUNCT_W'(6'b011000): begin
                        dec_fun   = FUN_W'(4'b0011);
                        dec_multi = 1'b1;
                    end
                    FUNCT_W'(6'b011010): begin
                        dec_fun   = FUN_W'(4'b0100);
                        dec_multi = 1'b1;
                        dec_div   = 1'b1;
                    end
                    FUNCT_W'(6'b100100): dec_fun = FUN_W'(4'b0101);
                    FUNCT_W'(6'b100101): dec_fun = FUN_W'(4'b0110);
                    FUNCT_W'(6'b100111): dec_fun = FUN_W'(4'b0111);
                    FUNCT_W'(6'b100110): dec_fun = FUN_W'(4'b1000);
                    FUNCT_W'(6'b101000): dec_fun = FUN_W'(4'b1001);
                    FUNCT_W'(6'b101001): dec_fun = FUN_W'(4'b1010);
                    FUNCT_W'(6'b001000): begin
                        dec_fun = FUN_W'(4'b1011);
                        dec_jr  = 1'b1;
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // -----------------------------------------------------------------------
    // Sticky trap (optional)
    // -----------------------------------------------------------------------
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    logic trap_reg;

    // Set while the illegal request is being reported; cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_reg <= 1'b0;
        end else if (state_reg == ISSUE && illegal_reg) begin
            trap_reg <= 1'b1;
        end
    end

    assign trap_active = trap_reg;
`else
    assign trap_active = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Handshake. The final cycle of an op (done) also accepts, so a new
    // request issues on the very next cycle without a bubble.
    // -----------------------------------------------------------------------
    assign op_done   = (state_reg == ISSUE && !illegal_reg && !multi_reg) ||
                       (state_reg == WAIT  && cnt_reg == CNT_W'(1));
    assign ready_int = !trap_active && (state_reg == IDLE || op_done);
    assign accept    = in_valid && ready_int;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            alu_fun_reg <= '0;
            multi_reg   <= 1'b0;
            div_reg     <= 1'b0;
            jr_reg      <= 1'b0;
            illegal_reg <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            alu_fun_reg <= alu_fun_next;
            multi_reg   <= multi_next;
            div_reg     <= div_next;
            jr_reg      <= jr_next;
            illegal_reg <= illegal_next;
            cnt_reg     <= cnt_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        alu_fun_next = alu_fun_reg;
        multi_next   = multi_reg;
        div_next     = div_reg;
        jr_next      = jr_reg;
        illegal_next = illegal_reg;
        cnt_next     = cnt_reg;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (illegal_reg) begin
                    state_next = IDLE;
                end else if (multi_reg) begin
                    // ISSUE is the first latency cycle; WAIT covers the rest.
                    state_next = WAIT;
                    cnt_next   = div_reg ? CNT_W'(DIV_CYCLES - 1)
                                         : CNT_W'(MULT_CYCLES - 1);
                end else begin
                    state_next = accept ? ISSUE : IDLE;
                end
            end
            WAIT: begin
                if (cnt_reg == CNT_W'(1)) begin
                    cnt_next   = '0;
                    state_next = accept ? ISSUE : IDLE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A new request overwrites the held code; illegal forces it to zero
        // (dec_fun is zero for illegal requests).
        if (accept) begin
            alu_fun_next = dec_fun;
            multi_next   = dec_multi;
            div_next     = dec_div;
            jr_next      = dec_jr;
            illegal_next = dec_illegal;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // Gated with rst_n so every output reads 0 while reset is held.
    assign in_ready  = rst_n && ready_int;
    assign alu_fun   = alu_fun_reg;
    assign fun_valid = (state_reg == ISSUE && !illegal_reg) || (state_reg == WAIT);
    assign busy      = (state_reg == ISSUE && !illegal_reg && multi_reg) ||
                       (state_reg == WAIT);
    assign done      = op_done;
    assign jr        = (state_reg == ISSUE) && jr_reg;
    assign illegal   = (state_reg == ISSUE && illegal_reg) || trap_active;

    // -----------------------------------------------------------------------
    // Simulation-only configuration and counter sanity checks
    // -----------------------------------------------------------------------
`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n) begin
            assert (MULT_CYCLES >= 2 && DIV_CYCLES >= 2 &&
                    MULT_CYCLES < (1 << CNT_W) && DIV_CYCLES < (1 << CNT_W));
            assert (!(state_reg == WAIT && cnt_reg == '0));
        end
    end
`endif

endmodule
